bit_serial_alu_seq: RTL and testbench

//  Bit-serial ALU sequencer: initiator side of the 1-bit ALU slice interface. It accepts two

---
 rtl/bit_serial_alu_seq.sv | 139 +++++++++++++
 tb/tb_bit_serial_alu_seq.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/bit_serial_alu_seq.sv
// Bit-serial ALU sequencer: walks two latched operands LSB-first through an external
// 1-bit slice, assembling the result and ZCV flags over WIDTH clocks.
//
// state  | meaning
// IDLE   | waiting for start; slice outputs parked at 0
// RUN    | one bit per clock through the slice, idx_q = bit being driven
// DONE   | one-cycle done pulse, result/flags final
module bit_serial_alu_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             carry_out,
    output logic             overflow,
    output logic             slice_a,
    output logic             slice_b,
    output logic             slice_cin,
    output logic [1:0]       slice_op,
    input  logic             slice_result,
    input  logic             slice_cout
);

    localparam int IW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [1:0] OP_SUB = 2'b11;
    localparam logic [IW-1:0] IDX_LAST = IW'(WIDTH - 1);
    localparam logic [IW-1:0] IDX_MSB_IN = IW'(WIDTH - 2);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [1:0]       op_q;
    logic [IW-1:0]    idx_q;
    logic             carry_q;
    logic             c_msb_in_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] result_q;
    logic [WIDTH-1:0] result_d;
    logic             zero_q;
    logic             carry_out_q;
    logic             overflow_q;
    logic             run;
    logic             is_sub;
    logic             is_arith;

    assign run      = (state_q == S_RUN);
    assign is_sub   = (op_q == OP_SUB);
    assign is_arith = op_q[1];

    // Slice is driven straight from registers so its combinational reply is settled by the edge.
    assign slice_a   = run & a_q[idx_q];
    assign slice_b   = run & (b_q[idx_q] ^ is_sub);
    assign slice_cin = run & carry_q;
    assign slice_op  = !run ? 2'b00 : (is_arith ? 2'b10 : op_q);

    always_comb begin
        result_d        = result_q;
        result_d[idx_q] = slice_result;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            a_q         <= '0;
            b_q         <= '0;
            op_q        <= 2'b00;
            idx_q       <= '0;
            carry_q     <= 1'b0;
            c_msb_in_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            result_q    <= '0;
            zero_q      <= 1'b0;
            carry_out_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        a_q     <= a;
                        b_q     <= b;
                        op_q    <= op;
                        carry_q <= (op == OP_SUB);
                        idx_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= S_RUN;
                    end
                end
                S_RUN: begin
                    result_q <= result_d;
                    carry_q  <= slice_cout;
                    if (idx_q == IDX_MSB_IN) begin
                        c_msb_in_q <= slice_cout;
                    end
                    if (idx_q == IDX_LAST) begin
                        zero_q      <= (result_d == '0);
                        carry_out_q <= is_arith & slice_cout;
                        overflow_q  <= is_arith & (c_msb_in_q ^ slice_cout);
                        done_q      <= 1'b1;
                        state_q     <= S_DONE;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign result    = result_q;
    assign zero      = zero_q;
    assign carry_out = carry_out_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_bit_serial_alu_seq.sv
// Directed bench for bit_serial_alu_seq (WIDTH=8) with a behavioural 1-bit slice and
// a scoreboard of expected results checked on every done pulse.
module tb_bit_serial_alu_seq;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         zero;
    logic         carry_out;
    logic         overflow;
    logic         slice_a;
    logic         slice_b;
    logic         slice_cin;
    logic [1:0]   slice_op;
    logic         slice_result;
    logic         slice_cout;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int done_cnt = 0;

    typedef struct {
        logic [W-1:0] r;
        logic         z;
        logic         c;
        logic         v;
        string        tag;
    } exp_t;

    exp_t sb[$];

    bit_serial_alu_seq #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .result(result), .zero(zero),
        .carry_out(carry_out), .overflow(overflow),
        .slice_a(slice_a), .slice_b(slice_b), .slice_cin(slice_cin), .slice_op(slice_op),
        .slice_result(slice_result), .slice_cout(slice_cout)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // 1-bit slice model
    always_comb begin
        logic [1:0] s;
        s = {1'b0, slice_a} + {1'b0, slice_b} + {1'b0, slice_cin};
        slice_result = 1'b0;
        slice_cout   = 1'b0;
        case (slice_op)
            2'b00: slice_result = slice_a & slice_b;
            2'b01: slice_result = slice_a | slice_b;
            2'b10: {slice_cout, slice_result} = s;
            default: ;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [1:0] o, input logic [W-1:0] x,
                                   input logic [W-1:0] y, input string tag);
        exp_t       e;
        logic [W:0] s;
        e.tag = tag;
        e.c   = 1'b0;
        e.v   = 1'b0;
        case (o)
            2'b00: e.r = x & y;
            2'b01: e.r = x | y;
            2'b10: begin
                s   = {1'b0, x} + {1'b0, y};
                e.r = s[W-1:0];
                e.c = s[W];
                e.v = (x[W-1] == y[W-1]) && (e.r[W-1] != x[W-1]);
            end
            default: begin
                s   = {1'b0, x} + {1'b0, ~y} + 1;
                e.r = s[W-1:0];
                e.c = s[W];
                e.v = (x[W-1] != y[W-1]) && (e.r[W-1] != x[W-1]);
            end
        endcase
        e.z = (e.r == '0);
        return e;
    endfunction

    // Scoreboard consumer
    always @(negedge clk) begin
        if (done) begin
            exp_t e;
            done_cnt++;
            if (sb.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                check({e.tag, "_result"}, 32'(result), 32'(e.r));
                check({e.tag, "_zero"}, 32'(zero), 32'(e.z));
                check({e.tag, "_carry"}, 32'(carry_out), 32'(e.c));
                check({e.tag, "_ovf"}, 32'(overflow), 32'(e.v));
            end
        end
    end

    task automatic wait_done(input string tag, output int t);
        bit seen = 1'b0;
        t = -1;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                t = cyc;
            end
        end
        if (!seen) check({tag, "_done_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic check_idle_outputs(input string tag);
        check(tag, {busy, done, result, zero, carry_out, overflow,
                    slice_a, slice_b, slice_cin, slice_op}, 32'd0);
    endtask

    task automatic run_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                          input string tag);
        int t0;
        int t;
        @(negedge clk);
        start = 1'b1;
        op = o;
        a = x;
        b = y;
        sb.push_back(model(o, x, y, tag));
        t0 = cyc;
        @(negedge clk);
        start = 1'b0;
        check({tag, "_busy_run"}, 32'(busy), 32'd1);
        check({tag, "_slice_drive"}, {slice_a, slice_b, slice_cin, slice_op},
              {x[0], y[0] ^ (o == 2'b11), (o == 2'b11), (o[1] ? 2'b10 : o)});
        wait_done(tag, t);
        check({tag, "_latency"}, 32'(t - t0), 32'(W + 1));
        check({tag, "_busy_done"}, 32'(busy), 32'd1);
        @(negedge clk);
        check({tag, "_post_done"}, {busy, done}, 32'd0);
    endtask

    initial begin
        int t1, t2, t3, dc;
        reset = 1'b1;
        start = 1'b0;
        op = 2'b00;
        a = '0;
        b = '0;
        repeat (3) @(negedge clk);
        check_idle_outputs("reset_state");
        reset = 1'b0;

        run_op(2'b10, 8'h7F, 8'h01, "add_7f_01");
        run_op(2'b11, 8'h05, 8'h05, "sub_05_05");
        run_op(2'b11, 8'h80, 8'h01, "sub_80_01");
        run_op(2'b00, 8'hF0, 8'h3C, "and_f0_3c");
        run_op(2'b01, 8'hF0, 8'h0C, "or_f0_0c");

        // start re-asserted mid-operation must be ignored
        dc = done_cnt;
        @(negedge clk);
        start = 1'b1; op = 2'b10; a = 8'h01; b = 8'h01;
        sb.push_back(model(2'b10, 8'h01, 8'h01, "add_ignore_start"));
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        start = 1'b1; op = 2'b11; a = 8'hFF;
        repeat (2) @(negedge clk);
        start = 1'b0; op = 2'b00;
        wait_done("add_ignore_start", t1);
        repeat (14) @(negedge clk);
        check("ignore_start_single_done", 32'(done_cnt - dc), 32'd1);

        // reset during RUN bit 4 aborts without a done pulse
        dc = done_cnt;
        @(negedge clk);
        start = 1'b1; op = 2'b10; a = 8'h33; b = 8'h11;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        check("abort_mid_run_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        check_idle_outputs("abort_outputs");
        reset = 1'b0;
        repeat (14) @(negedge clk);
        check("abort_no_done", 32'(done_cnt - dc), 32'd0);
        run_op(2'b10, 8'hFF, 8'h01, "add_ff_01");

        // start held high: back-to-back operations from IDLE only
        for (int i = 0; i < 3; i++) sb.push_back(model(2'b10, 8'h03, 8'h04, "b2b"));
        @(negedge clk);
        start = 1'b1; op = 2'b10; a = 8'h03; b = 8'h04;
        wait_done("b2b_1", t1);
        wait_done("b2b_2", t2);
        wait_done("b2b_3", t3);
        start = 1'b0;
        check("b2b_spacing_12", 32'(t2 - t1), 32'(W + 2));
        check("b2b_spacing_23", 32'(t3 - t2), 32'(W + 2));
        repeat (14) @(negedge clk);
        check("b2b_no_extra", 32'(sb.size()), 32'd0);
        check("b2b_idle", {busy, done}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
